// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default geometry and gray/binary pointer conversion,
// used by both the read-side and write-side controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 3;
    localparam int PTR_MAX_W       = 32;

    // Callers zero-extend narrower pointers into PTR_MAX_W and cast the result back.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the asynchronous FIFO: binary/gray read pointer,
// look-ahead empty, fill level, almost-empty and sticky underflow flag.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic                  rerr_clr,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  rerr
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] lvl_next;
    logic             pop;
    logic             underflow;

    // Next-state pointer, gray code and level; everything below is registered once.
    always_comb begin
        pop        = rinc & ~rempty;
        underflow  = rinc & rempty;
        rbin_next  = rbin + PTR_W'(pop);
        rgray_next = PTR_W'(bin2gray(PTR_MAX_W'(rbin_next)));
        wbin       = PTR_W'(gray2bin(PTR_MAX_W'(rq2_wptr)));
        lvl_next   = wbin - rbin_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            raddr   <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
            rerr    <= 1'b0;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            raddr   <= rbin_next[ADDR_WIDTH-1:0];
            rempty  <= (rgray_next == rq2_wptr);
            rlevel  <= lvl_next;
            raempty <= (lvl_next <= AE_TH);
            // A fresh underflow beats a simultaneous clear.
            if (underflow) begin
                rerr <= 1'b1;
            end else if (rerr_clr) begin
                rerr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (ADDR_WIDTH=3, AEMPTY_THRESH=1) with hand-computed expectations.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rinc;
    logic       rerr_clr;
    logic [3:0] rq2_wptr;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [3:0] rlevel;
    logic       rerr;

    int errors;
    int checks;

    fifo_rd_ctrl #(.ADDR_WIDTH(3), .AEMPTY_THRESH(1)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rinc     (rinc),
        .rerr_clr (rerr_clr),
        .rq2_wptr (rq2_wptr),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .raempty  (raempty),
        .rlevel   (rlevel),
        .rerr     (rerr)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rempty"},  32'(rempty),  32'd1);
        check({tag, ".raempty"}, 32'(raempty), 32'd1);
        check({tag, ".rlevel"},  32'(rlevel),  32'd0);
        check({tag, ".rptr"},    32'(rptr),    32'd0);
        check({tag, ".raddr"},   32'(raddr),   32'd0);
    endtask

    // Expected raddr / rlevel for the 8 pops starting from rbin=4 with wbin=12.
    logic [2:0] full_addr [8];
    logic [3:0] full_lvl  [8];

    initial begin
        errors   = 0;
        checks   = 0;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rerr_clr = 1'b0;
        rq2_wptr = 4'b0000;
        full_addr = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        full_lvl  = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

        // Reset
        tick();
        tick();
        #2 rrst_n = 1'b1;
        tick();
        check_reset_outputs("reset");
        check("reset.rerr", 32'(rerr), 32'd0);

        // Fill 3 words (gray 0010 = bin 3)
        rq2_wptr = 4'b0010;
        tick();
        check("fill.rempty",  32'(rempty),  32'd0);
        check("fill.rlevel",  32'(rlevel),  32'd3);
        check("fill.raempty", 32'(raempty), 32'd0);

        // Drain 3 words
        rinc = 1'b1;
        tick();
        check("drain1.raddr",   32'(raddr),   32'd1);
        check("drain1.rlevel",  32'(rlevel),  32'd2);
        check("drain1.raempty", 32'(raempty), 32'd0);
        tick();
        check("drain2.raddr",   32'(raddr),   32'd2);
        check("drain2.rlevel",  32'(rlevel),  32'd1);
        check("drain2.raempty", 32'(raempty), 32'd1);
        tick();
        check("drain3.raddr",  32'(raddr),  32'd3);
        check("drain3.rlevel", 32'(rlevel), 32'd0);
        check("drain3.rempty", 32'(rempty), 32'd1);
        check("drain3.rptr",   32'(rptr),   32'b0010);
        rinc = 1'b0;

        // Advance to rbin=4: one word in (gray(4)=0110), one pop
        rq2_wptr = 4'b0110;
        tick();
        check("step.rlevel", 32'(rlevel), 32'd1);
        rinc = 1'b1;
        tick();
        check("step.raddr",  32'(raddr),  32'd4);
        check("step.rempty", 32'(rempty), 32'd1);
        check("step.rptr",   32'(rptr),   32'b0110);
        rinc = 1'b0;

        // Full depth: gray(12)=1010 -> level 8
        rq2_wptr = 4'b1010;
        tick();
        check("full.rlevel",  32'(rlevel),  32'd8);
        check("full.rempty",  32'(rempty),  32'd0);
        check("full.raempty", 32'(raempty), 32'd0);
        rinc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("wrap%0d.raddr", i),  32'(raddr),  32'(full_addr[i]));
            check($sformatf("wrap%0d.rlevel", i), 32'(rlevel), 32'(full_lvl[i]));
        end
        check("wrap.rptr",   32'(rptr),   32'b1010);
        check("wrap.rempty", 32'(rempty), 32'd1);

        // Underflow: rinc held two more cycles while empty
        tick();
        tick();
        rinc = 1'b0;
        check("uflow.rptr",   32'(rptr),   32'b1010);
        check("uflow.raddr",  32'(raddr),  32'd4);
        check("uflow.rlevel", 32'(rlevel), 32'd0);
        check("uflow.rerr",   32'(rerr),   32'd1);
        tick();
        check("uflow.sticky", 32'(rerr), 32'd1);
        rerr_clr = 1'b1;
        tick();
        rerr_clr = 1'b0;
        check("uflow.clr", 32'(rerr), 32'd0);
        rerr_clr = 1'b1;
        rinc     = 1'b1;
        tick();
        rerr_clr = 1'b0;
        rinc     = 1'b0;
        tick();
        check("uflow.setwins", 32'(rerr), 32'd1);
        rerr_clr = 1'b1;
        tick();
        rerr_clr = 1'b0;
        check("uflow.clr2", 32'(rerr), 32'd0);

        // Simultaneous pop and write: gray(14)=1001 -> level 2, then gray(15)=1000 with pop
        rq2_wptr = 4'b1001;
        tick();
        check("simul.pre", 32'(rlevel), 32'd2);
        rq2_wptr = 4'b1000;
        rinc     = 1'b1;
        tick();
        rinc = 1'b0;
        check("simul.rlevel", 32'(rlevel), 32'd2);
        check("simul.rempty", 32'(rempty), 32'd0);
        check("simul.raddr",  32'(raddr),  32'd5);

        // Multi-step write jump: gray(4)=0110, wbin 4 - rbin 13 = 7 (mod 16)
        rq2_wptr = 4'b0110;
        tick();
        check("jump.rlevel", 32'(rlevel), 32'd7);
        check("jump.rempty", 32'(rempty), 32'd0);

        // Mid-operation asynchronous reset during a pop burst
        rinc = 1'b1;
        tick();
        check("burst.raddr",  32'(raddr),  32'd6);
        check("burst.rlevel", 32'(rlevel), 32'd6);
        #2 rrst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        check("async_rst.rerr", 32'(rerr), 32'd0);
        rq2_wptr = 4'b0000;
        #2 rrst_n = 1'b1;
        tick();
        check("post_rst.raddr",  32'(raddr),  32'd0);
        check("post_rst.rptr",   32'(rptr),   32'd0);
        check("post_rst.rempty", 32'(rempty), 32'd1);
        check("post_rst.rerr",   32'(rerr),   32'd1);
        rinc = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller for the asynchronous FIFO; successor to the fixed 3-bit read pointer block.
- Generalised to any address width. Gray pointer generation is arithmetic, not a lookup table.
- Adds registered look-ahead empty, fill level, programmable almost-empty and a sticky underflow flag.
- Sits in the rclk domain between the FIFO memory read port and the write-to-read 2-FF pointer synchroniser.

Parameters:
- ADDR_WIDTH, 3, memory address bits; depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AEMPTY_THRESH, 1, raempty asserts when the fill level is <= this value; legal range 0..2**ADDR_WIDTH.

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  asynchronous active-low reset.
- rinc  in  1  read request; pops one word when rempty=0.
- rerr_clr  in  1  clears rerr.
- rq2_wptr  in  ADDR_WIDTH+1  synchronised gray write pointer.
- raddr  out  ADDR_WIDTH  memory read address (binary).
- rptr  out  ADDR_WIDTH+1  gray read pointer, registered, feeds the read-to-write synchroniser.
- rempty  out  1  FIFO empty, registered.
- raempty  out  1  almost empty, registered.
- rlevel  out  ADDR_WIDTH+1  words available, 0..2**ADDR_WIDTH, registered.
- rerr  out  1  sticky underflow flag.

Behaviour:
- Reset state (asynchronous, rrst_n=0):
  - rbin=0, rptr=0, raddr=0.
  - rempty=1, raempty=1, rlevel=0, rerr=0.
- Pop condition: pop = rinc & ~rempty, using the registered rempty.
- Next-state values:
  - rbin_next = rbin + pop, modulo 2**(ADDR_WIDTH+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
- Register updates on every rclk edge:
  - rbin <= rbin_next; rptr <= rgray_next.
  - raddr <= rbin_next[ADDR_WIDTH-1:0].
  - raddr and rptr change on the same edge, with no one-cycle gray lag.
- Empty (look-ahead): rempty <= (rgray_next == rq2_wptr). It therefore asserts on the same edge as the last pop.
- Level:
  - wbin = gray-to-binary of rq2_wptr.
  - lvl_next = wbin - rbin_next, modulo 2**(ADDR_WIDTH+1).
  - rlevel <= lvl_next; raempty <= (lvl_next <= AEMPTY_THRESH).
- Latency:
  - A change on rq2_wptr appears on rempty, rlevel and raempty after one rclk edge.
  - A pop is reflected on those outputs on the same edge.
- Read data: raddr is the address of the word presented while rempty=0. The memory is read combinationally at raddr.
- Wrap-around: the binary pointer wraps 2**(ADDR_WIDTH+1)-1 to 0. The MSB distinguishes laps, so full depth gives rlevel=2**ADDR_WIDTH with rempty=0.
- Underflow: rinc=1 while rempty=1 causes no pointer change and rerr <= 1.
- rerr: stays set until rerr_clr=1. If rerr_clr and a new underflow occur in the same cycle, set wins (rerr stays 1).
- Simultaneous events: a pop and a write-pointer advance in the same cycle are both accounted for in lvl_next, so the level is net unchanged.
- Reset mid-operation: all state returns to reset values immediately, independent of rclk. Reads resume from address 0.
- Write-pointer constraint: rq2_wptr is assumed to change by at most one gray step per rclk (synchroniser guarantee).
  - Larger jumps must still produce the correct level, because the decode is pure gray-to-binary.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parametrised by width;
  - default ADDR_WIDTH constant;
  - reused by the write-side controller.
- No sub-module is required. An optional combinational gray2bin wrapper may be used if the package is unavailable to a tool.

Test Plan:
All scenarios use ADDR_WIDTH=3 and AEMPTY_THRESH=1.
- Reset: release rrst_n with rq2_wptr=0 -> rempty=1, raempty=1, rlevel=0, rptr=0000, raddr=0, rerr=0.
- Fill and drain 3 words:
  - Set rq2_wptr=0010 (bin 3) -> one edge later rempty=0, rlevel=3, raempty=0.
  - Hold rinc for 3 cycles -> raddr 1,2,3; rlevel 2,1,0; raempty=1 after the second pop.
  - rempty=1 and rptr=0010 on the third edge.
- Full depth and wrap:
  - Start from rbin=4; set rq2_wptr=gray(12)=1010 -> rlevel=8, rempty=0.
  - Pop 8 times -> raddr wraps 7->0 after 4 pops; final rptr=1010, rempty=1.
- Underflow: rinc=1 while empty for 2 cycles -> rptr, raddr and rlevel unchanged; rerr=1 and stays 1.
  - Pulse rerr_clr -> rerr=0.
  - rerr_clr together with rinc while empty -> rerr stays 1.
- Simultaneous pop and write: rlevel=2, rinc=1, rq2_wptr advances one gray step on the same edge -> rlevel stays 2, rempty=0.
- Mid-operation reset: assert rrst_n low between clock edges during a pop burst -> outputs go to reset values asynchronously.
  - After release with rq2_wptr=0, the first pop is blocked (rempty=1).
